// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit instruction
// words, writes them into instruction memory, and holds the processor in
// reset until the whole program has been loaded.
//
// Ports
//   clk          single clock, rising-edge active
//   reset        asynchronous active-low reset
//   s_valid      upstream byte valid
//   s_data       program byte (byte 0 of a word lands in bits [7:0])
//   s_last       final program byte, qualified by s_valid
//   s_ready      loader accepts a byte this cycle
//   mem_we       one-cycle instruction-memory write strobe
//   mem_addr     word address of the write (holds between writes)
//   mem_wdata    assembled word (holds between writes)
//   cpu_reset    active-high reset into the processor
//   done         program loaded, processor released
//   err_overflow program did not fit in DEPTH_WORDS (terminal)
//   word_count   number of words written so far (saturates at DEPTH_WORDS)
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned ADDR_W      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count
);

  if (DEPTH_WORDS == 0 || DEPTH_WORDS > (1 << ADDR_W)) begin : g_bad_depth
    $error("imem_loader: DEPTH_WORDS must be in 1..2**ADDR_W");
  end

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_WORDS - 1);
  localparam logic [ADDR_W:0]   MAX_COUNT = (ADDR_W + 1)'(DEPTH_WORDS);

  state_t            state;
  logic [31:0]       byte_buf;   // bytes received so far; unreceived bytes stay 0
  logic [1:0]        byte_idx;
  logic              last_seen;  // word being written carried s_last
  logic [ADDR_W-1:0] wr_addr;    // address of the word currently being assembled
  logic [31:0]       asm_word;
  logic              accept;

  // Outputs decode the registered state only; the async reset forces LOAD,
  // so cpu_reset/done/mem_we react to reset without a clock edge.
  assign s_ready      = reset && (state == LOAD);
  assign mem_we       = (state == WRITE);
  assign cpu_reset    = (state != DONE);
  assign done         = (state == DONE);
  assign err_overflow = (state == ERROR);

  assign accept = s_valid && s_ready;

  // Buffer with the incoming byte merged into its lane.
  always_comb begin
    asm_word = byte_buf;
    asm_word[{byte_idx, 3'b000} +: 8] = s_data;
  end

  // mem_addr/mem_wdata are loaded only when a word completes, separately from
  // the assembly buffer and running address, so they hold steady between
  // writes while the next word is being built.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= LOAD;
      byte_buf   <= '0;
      byte_idx   <= '0;
      last_seen  <= 1'b0;
      wr_addr    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (byte_idx == 2'd3 || s_last) begin
              state     <= WRITE;
              mem_wdata <= asm_word;
              mem_addr  <= wr_addr;
              last_seen <= s_last;
              byte_buf  <= '0;
              byte_idx  <= '0;
            end else begin
              byte_buf <= asm_word;
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        WRITE: begin
          if (word_count != MAX_COUNT) begin
            word_count <= word_count + (ADDR_W + 1)'(1);
          end
          if (last_seen) begin
            state <= DONE;
          end else if (wr_addr == LAST_ADDR) begin
            state <= ERROR;
          end else begin
            state   <= LOAD;
            wr_addr <= wr_addr + ADDR_W'(1);
          end
        end
        default: begin
          // DONE and ERROR are terminal until reset.
        end
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DEPTH_WORDS, 64, number of 32-bit instruction-memory words the loader may write.
REQ-002 Parameter: ADDR_W, 6, word-address width; the block SHALL require DEPTH_WORDS <= 2**ADDR_W.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port: s_valid  input  1  upstream byte-stream valid.
REQ-006 Port: s_data  input  8  program byte, little-endian within each word.
REQ-007 Port: s_last  input  1  marks final program byte; qualified by s_valid.
REQ-008 Port: s_ready  output  1  loader accepts a byte this cycle.
REQ-009 Port: mem_we  output  1  one-cycle write strobe to instruction memory.
REQ-010 Port: mem_addr  output  ADDR_W  word address of the write.
REQ-011 Port: mem_wdata  output  32  assembled instruction word.
REQ-012 Port: cpu_reset  output  1  active-high reset driven into the processor top.
REQ-013 Port: done  output  1  program fully loaded; processor released.
REQ-014 Port: err_overflow  output  1  sticky: program exceeded DEPTH_WORDS.
REQ-015 Port: word_count  output  ADDR_W+1  number of words written so far.

Function
REQ-016 The block SHALL be a four-state FSM: LOAD, WRITE, DONE, ERROR; all outputs registered or decoded from registered state only.
REQ-017 Handshake: a byte is accepted iff s_valid && s_ready at a rising edge; s_data/s_last are ignored otherwise.
REQ-018 LOAD: s_ready=1, mem_we=0; the k-th accepted byte of a word (k=0..3) SHALL be stored in bits [8k+7:8k].
REQ-019 LOAD->WRITE on accepting the 4th byte of a word, or on accepting any byte with s_last=1.
REQ-020 Bytes not received before s_last SHALL be written as 0x00 (partial final word zero-padded in upper bytes).
REQ-021 WRITE: lasts exactly one cycle; mem_we=1, s_ready=0, mem_addr=current word address, mem_wdata=assembled word.
REQ-022 WRITE->DONE if the word contained s_last; else, if mem_addr == DEPTH_WORDS-1, WRITE->ERROR; else WRITE->LOAD with address +1 and byte buffer cleared.
REQ-023 word_count SHALL increment by 1 on each WRITE cycle edge and never wrap; max value DEPTH_WORDS.
REQ-024 DONE: s_ready=0, mem_we=0, cpu_reset=0, done=1; state held until reset (terminal).
REQ-025 ERROR: s_ready=0, mem_we=0, cpu_reset=1, err_overflow=1, done=0; state held until reset (terminal).
REQ-026 cpu_reset SHALL be 1 in LOAD, WRITE and ERROR; it first reads 0 in the cycle after the final WRITE cycle.
REQ-027 s_valid low for any number of cycles in LOAD SHALL stall assembly with no state or buffer change.
REQ-028 mem_addr and mem_wdata SHALL hold their last values when mem_we=0 (no glitching requirement on memory side beyond mem_we).

Reset
REQ-029 reset=0 SHALL asynchronously force: state=LOAD, s_ready=1 (upon release), mem_we=0, mem_addr=0, mem_wdata=0, byte index=0, word_count=0, cpu_reset=1, done=0, err_overflow=0.
REQ-030 While reset=0, s_ready SHALL be 0; no byte is accepted in a cycle where reset is asserted.
REQ-031 Reset asserted mid-load (any state) SHALL discard the partial word and restart loading at address 0; already-written memory is not cleared.

Verification
REQ-032 Bytes 93,00,50,00,13,01,A0,00(last) back-to-back -> two WRITE cycles: addr0=0x00500093, addr1=0x00A00113; word_count=2; cpu_reset falls and done rises the cycle after second write.
REQ-033 Bytes EF,BE(last) -> single write addr0=0x0000BEEF; done=1; word_count=1.
REQ-034 DEPTH_WORDS=4, 17 bytes without s_last -> exactly 4 writes (addr0..3), then ERROR: err_overflow=1, cpu_reset=1, s_ready=0, 17th byte not accepted.
REQ-035 Same stream as REQ-032 with s_valid dropped for 3 cycles between every byte -> identical memory contents and word_count; s_ready=0 only during the two WRITE cycles.
REQ-036 Reset pulsed low after 6 bytes of REQ-032 stream, then full stream resent -> writes start at addr0, final state identical to REQ-032, word_count=2.
REQ-037 Asynchronous check: reset asserted between clock edges -> cpu_reset=1, mem_we=0, done=0 immediately, without waiting for clk.
